// File: rtl/data_mem_access_unit.sv
// Initiator for the word-wide data memory: byte/half/word loads and stores.
// Sub-word stores use read-modify-write. Optional alignment check: `MEM_ACCESS_MISALIGN_CHK_EN.
module data_mem_access_unit #(
  parameter int unsigned MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr,
  output logic [31:0] din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH) << 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_word_q, old_word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_ok;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] store_merge;

  // Legality of the incoming request, judged before anything is latched.
  always_comb begin
    req_ok = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: req_ok = 1'b1;
      F3_BU, F3_HU:     req_ok = !req_write;
      default:          req_ok = 1'b0;
    endcase
    if ({1'b0, req_addr} >= ADDR_LIMIT) begin
      req_ok = 1'b0;
    end
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
    if (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) begin
      req_ok = 1'b0;
    end
    if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) begin
      req_ok = 1'b0;
    end
`endif
  end

  always_comb begin
    lane_b = mem_dout[7:0];
    case (addr_q[1:0])
      2'd0:    lane_b = mem_dout[7:0];
      2'd1:    lane_b = mem_dout[15:8];
      2'd2:    lane_b = mem_dout[23:16];
      default: lane_b = mem_dout[31:24];
    endcase
    lane_h = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    case (funct3_q)
      F3_B:    load_ext = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_ext = {24'h000000, lane_b};
      F3_H:    load_ext = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_ext = {16'h0000, lane_h};
      default: load_ext = mem_dout;
    endcase
  end

  // Old word with the addressed lane replaced; word stores bypass the old word.
  always_comb begin
    store_merge = old_word_q;
    case (funct3_q)
      F3_B: begin
        case (addr_q[1:0])
          2'd0:    store_merge[7:0]   = wdata_q[7:0];
          2'd1:    store_merge[15:8]  = wdata_q[7:0];
          2'd2:    store_merge[23:16] = wdata_q[7:0];
          default: store_merge[31:24] = wdata_q[7:0];
        endcase
      end
      F3_H: begin
        if (addr_q[1]) begin
          store_merge[31:16] = wdata_q[15:0];
        end else begin
          store_merge[15:0] = wdata_q[15:0];
        end
      end
      default: store_merge = wdata_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    old_word_d = old_word_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          is_write_d = req_write;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          old_word_d = 32'h0;
          rdata_d    = 32'h0;
          if (!req_ok) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = (req_write && (req_funct3 == F3_W)) ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_READ: begin
        if (is_write_q) begin
          old_word_d = mem_dout;
          state_d    = ST_WRITE;
        end else begin
          rdata_d = load_ext;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      old_word_q <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      old_word_q <= old_word_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Memory strobes decode straight from state so an async reset drops them at once.
  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;
  assign resp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
  assign mem_read   = (state_q == ST_READ);
  assign mem_write  = (state_q == ST_WRITE);
  assign addr       = ((state_q == ST_READ) || (state_q == ST_WRITE)) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign din        = (state_q == ST_WRITE) ? store_merge : 32'h0;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: directed vectors plus randomized
// accesses checked against a byte-level reference memory model.
module tb_data_mem_access_unit;

   localparam int unsigned MEM_DEPTH = 16384;
   localparam int WIN_WORDS = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] addr;
   logic [31:0] din;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_dout;

   logic [31:0] mem [0:MEM_DEPTH-1];
   logic [31:0] refMem [0:WIN_WORDS-1];
   logic        plEn;
   logic [13:0] plIdx;
   logic [31:0] plData;

   int checks = 0;
   int fails = 0;

   logic        obsValid;
   logic [31:0] obsData;
   logic        obsErr;
   int          obsLat;
   logic        sawRead;
   logic        sawWrite;
   logic        sawBoth;

   data_mem_access_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_funct3(req_funct3),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .addr(addr),
      .din(din),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_dout(mem_dout)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Word memory: combinational read, write on rising edge, plus a preload path
   assign mem_dout = mem_read ? mem[addr[15:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_write) begin
         mem[addr[15:2]] <= din;
      end else if (plEn) begin
         mem[plIdx] <= plData;
      end
   end

   // One comparison: counts it, and on mismatch reports tag, observed and expected
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] val);
      plEn = 1'b1;
      plIdx = 14'(idx);
      plData = val;
      @(posedge clk);
      #1 plEn = 1'b0;
      refMem[idx] = val;
   endtask

   // Reference model: legality, lane extraction and lane merge computed from byte arithmetic
   task automatic refAccess(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] eData, output logic eErr, output int eLat);
      int size;
      int off;
      int idx;
      logic isLegal;
      longint unsigned mask;
      longint unsigned word;
      longint unsigned val;
      isLegal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size = 1 << (int'(f3) % 4);
      if (a >= 32'(MEM_DEPTH * 4)) isLegal = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
      if (isLegal && ((int'(a) % size) != 0)) isLegal = 1'b0;
`endif
      eData = 32'h0;
      eErr = !isLegal;
      eLat = 1;
      if (!isLegal) return;
      off = ((int'(a) % 4) / size) * size;
      mask = (64'd1 << (8 * size)) - 64'd1;
      idx = int'(a >> 2);
      word = 64'(refMem[idx]);
      if (!w) begin
         val = (word >> (8 * off)) & mask;
         if ((f3 < 3'd4) && val[8 * size - 1]) val = val | ~mask;
         eData = val[31:0];
         eLat = 2;
      end else begin
         val = (word & ~(mask << (8 * off))) | ((64'(d) & mask) << (8 * off));
         refMem[idx] = val[31:0];
         eLat = (size == 4) ? 2 : 3;
      end
   endtask

   // Issues one request from an idle negedge and watches it to completion (bounded)
   task automatic applyStimulus(input string tag, input logic w, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] d);
      int k;
      checkOutput({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = w;
      req_funct3 = f3;
      req_addr = a;
      req_wdata = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      k = 0;
      obsValid = 1'b0;
      obsData = 32'h0;
      obsErr = 1'b0;
      sawRead = 1'b0;
      sawWrite = 1'b0;
      sawBoth = 1'b0;
      while ((k < 10) && !obsValid) begin
         @(negedge clk);
         k++;
         sawRead = sawRead | mem_read;
         sawWrite = sawWrite | mem_write;
         sawBoth = sawBoth | (mem_read & mem_write);
         if (resp_valid) begin
            obsValid = 1'b1;
            obsData = resp_rdata;
            obsErr = resp_err;
         end
      end
      obsLat = k;
      @(negedge clk);
   endtask

   // Runs one access through DUT and model and compares every observable
   task automatic doAccess(input string tag, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
      logic [31:0] eData;
      logic eErr;
      int eLat;
      refAccess(w, f3, a, d, eData, eErr, eLat);
      applyStimulus(tag, w, f3, a, d);
      checkOutput({tag, ".valid"}, 32'(obsValid), 32'd1);
      checkOutput({tag, ".rdata"}, obsData, eData);
      checkOutput({tag, ".err"}, 32'(obsErr), 32'(eErr));
      checkOutput({tag, ".latency"}, 32'(obsLat), 32'(eLat));
      checkOutput({tag, ".rd_wr_overlap"}, 32'(sawBoth), 32'd0);
      if (eErr) begin
         checkOutput({tag, ".no_read"}, 32'(sawRead), 32'd0);
         checkOutput({tag, ".no_write"}, 32'(sawWrite), 32'd0);
      end else if (w) begin
         checkOutput({tag, ".mem_word"}, mem[a[15:2]], refMem[int'(a >> 2)]);
         if (f3 == 3'b010) checkOutput({tag, ".no_read"}, 32'(sawRead), 32'd0);
      end else begin
         checkOutput({tag, ".no_write"}, 32'(sawWrite), 32'd0);
      end
   endtask

   initial begin
      logic w;
      logic [2:0] f3;
      logic [31:0] a;
      logic [31:0] saved;

      reset = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_funct3 = 3'b000;
      req_addr = 32'h0;
      req_wdata = 32'h0;
      plEn = 1'b0;
      plIdx = 14'h0;
      plData = 32'h0;

      @(negedge clk);
      checkOutput("rst.hold.mem_write", 32'(mem_write), 32'd0);
      checkOutput("rst.hold.mem_read", 32'(mem_read), 32'd0);
      checkOutput("rst.hold.resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rst.ready", 32'(req_ready), 32'd1);
      checkOutput("rst.addr", addr, 32'h0);
      checkOutput("rst.din", din, 32'h0);
      checkOutput("rst.rdata", resp_rdata, 32'h0);
      checkOutput("rst.err", 32'(resp_err), 32'd0);

      for (int i = 0; i < WIN_WORDS; i++) preload(i, $urandom);
      preload(4, 32'h8081F2F3);
      preload(8, 32'hDEADBEEF);
      @(negedge clk);

      doAccess("lb_11", 1'b0, 3'b000, 32'h11, 32'h0);
      checkOutput("lb_11.spec", obsData, 32'hFFFFFFF2);
      doAccess("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0);
      checkOutput("lbu_13.spec", obsData, 32'h00000080);
      doAccess("lh_12", 1'b0, 3'b001, 32'h12, 32'h0);
      checkOutput("lh_12.spec", obsData, 32'hFFFF8081);

      doAccess("sb_21", 1'b1, 3'b000, 32'h21, 32'h55);
      checkOutput("sb_21.spec", mem[8], 32'hDEAD55EF);
      doAccess("sh_22", 1'b1, 3'b001, 32'h22, 32'h1234);
      checkOutput("sh_22.spec", mem[8], 32'h123455EF);

      doAccess("sw_20", 1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
      doAccess("lw_20", 1'b0, 3'b010, 32'h20, 32'h0);
      checkOutput("lw_20.spec", obsData, 32'hDEADBEEF);

      doAccess("lw_oor", 1'b0, 3'b010, 32'h0001_0000, 32'h0);
      checkOutput("lw_oor.spec", 32'(obsErr), 32'd1);
      doAccess("f3_011", 1'b0, 3'b011, 32'h20, 32'h0);
      checkOutput("f3_011.spec", 32'(obsErr), 32'd1);
      doAccess("sbu_bad", 1'b1, 3'b100, 32'h24, 32'hFF);

      doAccess("lw_22", 1'b0, 3'b010, 32'h22, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_CHK_EN
      checkOutput("lw_22.spec", 32'(obsErr), 32'd1);
`else
      checkOutput("lw_22.spec", obsData, 32'hDEADBEEF);
`endif

      for (int n = 0; n < 60; n++) begin
         w = 1'($urandom_range(0, 1));
         f3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : (w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
         a = ($urandom_range(0, 9) == 0) ? 32'h0001_0000 + 32'($urandom_range(0, 4095)) : 32'($urandom_range(0, WIN_WORDS * 4 - 1));
         doAccess($sformatf("rnd%0d", n), w, f3, a, $urandom);
      end

      // Abandon a word store while its write strobe is up
      saved = refMem[16];
      req_valid = 1'b1;
      req_write = 1'b1;
      req_funct3 = 3'b010;
      req_addr = 32'h40;
      req_wdata = 32'hA5A5A5A5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid.write_up", 32'(mem_write), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("rst_mid.write_drop", 32'(mem_write), 32'd0);
      checkOutput("rst_mid.addr", addr, 32'h0);
      checkOutput("rst_mid.din", din, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rst_mid.word_kept", mem[16], saved);
      checkOutput("rst_mid.ready", 32'(req_ready), 32'd1);
      checkOutput("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      doAccess("post_rst_lw", 1'b0, 3'b010, 32'h40, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
